// File: rtl/memcpy_seq.sv
// Multi-cycle word-copy sequencer for the RV32I memcpy extension, with nibble-merged final word.
// Define MEMCPY_ABORT_EN to add the abort input that cuts a copy short.
module memcpy_seq #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef MEMCPY_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic [2:0]       funct3,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      mem_addr,
   output logic             mem_re,
   output logic             mem_we,
   output logic [31:0]      mem_wdata,
   output logic             stall,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {StIdle, StRdSrc, StLatSrc, StLatDst, StWr, StDone} state_e;

   state_e           state_q, state_d;
   logic [31:0]      src_ptr_q, dst_ptr_q;
   logic [31:0]      src_q, dst_q;
   logic [LEN_W-1:0] remaining_q;
   logic [2:0]       funct3_q;

   logic             last_word;
   logic             partial;
   logic             abort_req;
   logic [4:0]       keep_shamt;
   logic [31:0]      src_mask;
   logic [31:0]      merged;

`ifdef MEMCPY_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign last_word = (remaining_q == LEN_W'(1));
   assign partial   = last_word && (funct3_q != 3'd7);

   // Low 4*(funct3+1) bits come from the source, the rest from the destination.
   assign keep_shamt = 5'd28 - {funct3_q, 2'b00};
   assign src_mask   = 32'hFFFF_FFFF >> keep_shamt;
   assign merged     = (src_q & src_mask) | (dst_q & ~src_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (len == '0) ? StDone : StRdSrc;
            end
         end
         StRdSrc:  state_d = abort_req ? StDone : StLatSrc;
         StLatSrc: begin
            if (abort_req) begin
               state_d = StDone;
            end else begin
               state_d = partial ? StLatDst : StWr;
            end
         end
         StLatDst: state_d = abort_req ? StDone : StWr;
         // An abort here still lets the current write land.
         StWr:     state_d = (last_word || abort_req) ? StDone : StRdSrc;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ptr_q   <= '0;
         dst_ptr_q   <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         funct3_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  src_ptr_q   <= src_addr & 32'hFFFF_FFFC;
                  dst_ptr_q   <= dst_addr & 32'hFFFF_FFFC;
                  remaining_q <= len;
                  funct3_q    <= funct3;
               end
            end
            StLatSrc: src_q <= mem_rdata;
            StLatDst: dst_q <= mem_rdata;
            StWr: begin
               src_ptr_q   <= src_ptr_q + 32'd4;
               dst_ptr_q   <= dst_ptr_q + 32'd4;
               remaining_q <= remaining_q - LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      stall     = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         StIdle: stall = start;
         StRdSrc: begin
            mem_addr = src_ptr_q;
            mem_re   = 1'b1;
            stall    = 1'b1;
         end
         StLatSrc: begin
            stall = 1'b1;
            // Fetch the old destination word for the final merge.
            if (partial) begin
               mem_addr = dst_ptr_q;
               mem_re   = 1'b1;
            end
         end
         StLatDst: stall = 1'b1;
         StWr: begin
            mem_addr  = dst_ptr_q;
            mem_we    = 1'b1;
            mem_wdata = partial ? merged : src_q;
            stall     = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_memcpy_seq.sv
// Bench for memcpy_seq: word-level memory model, per-copy expected trace and final-image checks.
// Abort scenarios are exercised when MEMCPY_ABORT_EN is defined.
module tb_memcpy_seq;
   localparam int unsigned LEN_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [LEN_W-1:0] len = '0;
   logic [2:0]       funct3 = '0;
   logic [31:0]      mem_rdata;
   logic [31:0]      mem_addr;
   logic             mem_re;
   logic             mem_we;
   logic [31:0]      mem_wdata;
   logic             stall;
   logic             busy;
   logic             done;

   always #5 clk = ~clk;

   memcpy_seq #(.LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MEMCPY_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .funct3    (funct3),
      .mem_rdata (mem_rdata),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .stall     (stall),
      .busy      (busy),
      .done      (done)
   );

   // 4 KiB single-port data memory, one-cycle read latency; preload port shares the write path.
   logic [31:0] mem [0:1023];
   logic        pl_we = 1'b0;
   logic [9:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_we) mem[pl_idx] <= pl_data;
      else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
      mem_rdata <= mem_re ? mem[mem_addr[11:2]] : 32'h0;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem[a[11:2]];
   endfunction

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_idx = a[11:2]; pl_data = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   function automatic logic [31:0] merge_word(input logic [2:0] n, input logic [31:0] s,
                                              input logic [31:0] d);
      int bits;
      logic [31:0] mask;
      bits = 4 * (int'(n) + 1);
      mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
      return (s & mask) | (d & ~mask);
   endfunction

   // Expected trace of the copy in flight, in cycles counted from the start cycle (cycle 0).
   bit          chk_en = 1'b0;
   int          cyc = 0;
   int          done_cyc = 0;
   int          obs_done = -1;
   int          rd_cyc[$];
   logic [31:0] rd_addr[$];
   int          wr_cyc[$];
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_re, exp_we;
         exp_re = (rd_cyc.size() > 0) && (rd_cyc[0] == cyc);
         exp_we = (wr_cyc.size() > 0) && (wr_cyc[0] == cyc);
         chk("stall", 32'(stall), 32'(cyc < done_cyc));
         chk("busy", 32'(busy), 32'(cyc >= 1 && cyc <= done_cyc));
         chk("done", 32'(done), 32'(cyc == done_cyc));
         chk("mem_re", 32'(mem_re), 32'(exp_re));
         chk("mem_we", 32'(mem_we), 32'(exp_we));
         chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
         if (done) obs_done = cyc;
         if (exp_re) begin
            chk("rd_addr", mem_addr, rd_addr[0]);
            void'(rd_cyc.pop_front());
            void'(rd_addr.pop_front());
         end
         if (exp_we) begin
            chk("wr_addr", mem_addr, wr_addr[0]);
            chk("wr_data", mem_wdata, wr_data[0]);
            void'(wr_cyc.pop_front());
            void'(wr_addr.pop_front());
            void'(wr_data.pop_front());
         end
         if (cyc > done_cyc) begin
            chk("trace_drained", 32'(rd_cyc.size() + wr_cyc.size()), 32'd0);
            chk_en = 1'b0;
         end
         cyc++;
      end
   end

   // Builds the expected trace from current memory, runs the copy, then checks the final image.
   // repulse > 0 re-asserts start with unrelated operands in that cycle.
   task automatic run_copy(input logic [31:0] sa, input logic [31:0] da, input int l,
                           input logic [2:0] f3, input int repulse);
      logic [31:0] s, d, a_s, a_d, w;
      logic [31:0] fin_addr[$];
      logic [31:0] fin_data[$];
      int base;
      bit part;
      s = sa & ~32'h3;
      d = da & ~32'h3;
      rd_cyc.delete(); rd_addr.delete();
      wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
      for (int k = 0; k < l; k++) begin
         a_s  = s + 32'(4 * k);
         a_d  = d + 32'(4 * k);
         base = 1 + 3 * k;
         part = (k == l - 1) && (f3 != 3'd7);
         rd_cyc.push_back(base); rd_addr.push_back(a_s);
         if (part) begin
            rd_cyc.push_back(base + 1); rd_addr.push_back(a_d);
            w = merge_word(f3, rd_mem(a_s), rd_mem(a_d));
         end else begin
            w = rd_mem(a_s);
         end
         wr_cyc.push_back(part ? base + 3 : base + 2);
         wr_addr.push_back(a_d); wr_data.push_back(w);
         fin_addr.push_back(a_d); fin_data.push_back(w);
      end
      done_cyc = (l == 0) ? 1 : 1 + 3 * l + ((f3 != 3'd7) ? 1 : 0);
      obs_done = -1;
      @(posedge clk); #1;
      src_addr = sa; dst_addr = da; len = LEN_W'(l); funct3 = f3; start = 1'b1;
      cyc = 0; chk_en = 1'b1;
      for (int i = 1; i <= done_cyc + 4 && chk_en; i++) begin
         @(posedge clk); #1;
         if (i == repulse) begin
            start = 1'b1; src_addr = 32'hF00; dst_addr = 32'hF80; len = LEN_W'(7); funct3 = 3'd0;
         end else begin
            start = 1'b0;
         end
      end
      chk("copy_timeout", 32'(chk_en), 32'd0);
      chk_en = 1'b0;
      start = 1'b0;
      foreach (fin_addr[k]) chk("final_mem", rd_mem(fin_addr[k]), fin_data[k]);
   endtask

`ifdef MEMCPY_ABORT_EN
   task automatic abort_copy(input logic [31:0] sa, input logic [31:0] da, input int l,
                             input int ab_cyc, input int exp_done, input int exp_wr);
      int seen_done, writes;
      seen_done = -1;
      writes = 0;
      @(posedge clk); #1;
      src_addr = sa; dst_addr = da; len = LEN_W'(l); funct3 = 3'd7; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         abort = (i == ab_cyc);
         #1;
         if (mem_we) writes++;
         if (done && seen_done < 0) seen_done = i;
      end
      abort = 1'b0;
      chk("abort_done_cycle", 32'(seen_done), 32'(exp_done));
      chk("abort_writes", 32'(writes), 32'(exp_wr));
      chk("abort_idle", 32'(busy), 32'd0);
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #3;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_we", 32'(mem_we), 32'd0);
      chk("reset_re", 32'(mem_re), 32'd0);
      chk("reset_addr", mem_addr, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single full word
      poke(32'h100, 32'hDEAD_BEEF);
      poke(32'h200, 32'h0);
      run_copy(32'h100, 32'h200, 1, 3'd7, 0);
      chk("t1_word", rd_mem(32'h200), 32'hDEAD_BEEF);
      chk("t1_done_cycle", 32'(obs_done), 32'd4);

      // Two words, partial final
      poke(32'h300, 32'h1111_1111);
      poke(32'h304, 32'hAAAA_BBBB);
      poke(32'h400, 32'h0);
      poke(32'h404, 32'h1234_5678);
      run_copy(32'h300, 32'h400, 2, 3'd3, 0);
      chk("t2_word0", rd_mem(32'h400), 32'h1111_1111);
      chk("t2_word1", rd_mem(32'h404), 32'h1234_BBBB);
      chk("t2_done_cycle", 32'(obs_done), 32'd8);

      // Single-nibble merge
      poke(32'h500, 32'hABCD_EF9A);
      poke(32'h600, 32'h1234_5678);
      run_copy(32'h500, 32'h600, 1, 3'd0, 0);
      chk("t3_word", rd_mem(32'h600), 32'h1234_567A);
      chk("t3_done_cycle", 32'(obs_done), 32'd5);

      // Zero length
      run_copy(32'h100, 32'h200, 0, 3'd7, 0);
      chk("t4_done_cycle", 32'(obs_done), 32'd1);

      // Start re-pulsed mid-copy
      poke(32'h700, 32'h0101_0101);
      poke(32'h704, 32'h0202_0202);
      poke(32'h708, 32'h0303_0303);
      run_copy(32'h700, 32'h800, 3, 3'd7, 4);
      chk("t5_word2", rd_mem(32'h808), 32'h0303_0303);
      chk("t5_untouched", rd_mem(32'hF80), 32'h0);

      // Misaligned operands, 24-bit final merge
      poke(32'h900, 32'hCAFE_0001);
      poke(32'h904, 32'h7654_3210);
      poke(32'h980, 32'h0);
      poke(32'h984, 32'hFFFF_FFFF);
      run_copy(32'h903, 32'h982, 2, 3'd5, 0);
      chk("t6_word1", rd_mem(32'h984), 32'hFF54_3210);

      // Asynchronous reset during the second WR
      poke(32'hA00, 32'h0BAD_F00D);
      poke(32'hA04, 32'hCAFE_BABE);
      poke(32'hB00, 32'h5555_5555);
      poke(32'hB04, 32'h6666_6666);
      @(posedge clk); #1;
      src_addr = 32'hA00; dst_addr = 32'hB00; len = LEN_W'(2); funct3 = 3'd7; start = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("pre_reset_we", 32'(mem_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_kept_word0", rd_mem(32'hB00), 32'h0BAD_F00D);
      chk("rst_no_word1", rd_mem(32'hB04), 32'h6666_6666);
      run_copy(32'hA00, 32'hB00, 2, 3'd6, 0);
      chk("recover_word1", rd_mem(32'hB04), 32'h6AFE_BABE);

`ifdef MEMCPY_ABORT_EN
      poke(32'hC00, 32'h1000_0001);
      poke(32'hC04, 32'h2000_0002);
      poke(32'hC08, 32'h3000_0003);
      poke(32'hD00, 32'h0);
      poke(32'hD04, 32'h0);
      poke(32'hD08, 32'h0);
      abort_copy(32'hC00, 32'hD00, 4, 5, 6, 1);
      chk("abort_lat_word0", rd_mem(32'hD00), 32'h1000_0001);
      chk("abort_lat_word1", rd_mem(32'hD04), 32'h0);
      poke(32'hD00, 32'h0);
      abort_copy(32'hC00, 32'hD00, 4, 6, 7, 2);
      chk("abort_wr_word1", rd_mem(32'hD04), 32'h2000_0002);
      chk("abort_wr_word2", rd_mem(32'hD08), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memcpy_seq.md
# memcpy_seq

Multi-cycle sequencer for the RV32I memcpy extension. On a start pulse from EX, it copies `len` 32-bit words from `src_addr` to `dst_addr` through the single-port data memory, stalling the pipeline meanwhile. The final word is nibble-merged with its existing destination contents under `funct3` control: the low 4·(funct3+1) bits come from the source and the rest are kept from the destination. It sits beside the data memory, muxed ahead of the MEM-stage memory port.

## Interface
- `LEN_W`, default 16: width of the word-count operand.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request from EX.
- `src_addr` input 32: source byte address. Bits [1:0] are ignored.
- `dst_addr` input 32: destination byte address. Bits [1:0] are ignored.
- `len` input LEN_W: number of words to copy.
- `funct3` input 3: final-word merge selector. 3'b111 means a full-word copy.
- `mem_rdata` input 32: data memory read data, valid one cycle after the address.
- `mem_addr` output 32: memory address, with bits [1:0] always 0.
- `mem_re` output 1: memory read enable.
- `mem_we` output 1: memory write enable.
- `mem_wdata` output 32: memory write data.
- `stall` output 1: pipeline hold.
- `busy` output 1: sequencer not in IDLE.
- `done` output 1: one-cycle completion pulse.
- `abort` input 1: present only with `MEMCPY_ABORT_EN`.

## Operation
- States: IDLE, RD_SRC, LAT_SRC, LAT_DST, WR, DONE.
- IDLE:
  - `start` latches `src_ptr`, `dst_ptr`, `remaining=len` and `funct3`.
  - If `len`≠0, go to RD_SRC; if `len`=0, go to DONE.
  - `start` is ignored in every other state.
- RD_SRC: `mem_addr`=`src_ptr`, `mem_re`=1. Go to LAT_SRC.
- LAT_SRC: `src_q`←`mem_rdata`.
  - If `remaining`=1 and `funct3`≠7: drive `mem_addr`=`dst_ptr`, `mem_re`=1, and go to LAT_DST.
  - Otherwise go to WR.
- LAT_DST: `dst_q`←`mem_rdata`. Go to WR.
- WR: `mem_addr`=`dst_ptr`, `mem_we`=1.
  - `mem_wdata` is the merge for the final partial word, otherwise `src_q`.
  - Merge for funct3=n: {`dst_q`[31:4(n+1)], `src_q`[4(n+1)-1:0]}.
  - Update pointers: `src_ptr`+=4, `dst_ptr`+=4, `remaining`−=1.
  - If `remaining` was 1, go to DONE; otherwise go to RD_SRC.
- Pointers wrap modulo 2^32.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `mem_re` and `mem_we` are never both 1 in the same cycle. Both are 0 in IDLE and DONE.
- `stall` = (`start` & IDLE) | (state ∉ {IDLE, DONE}). `stall` is combinational, so the pipeline freezes in the same cycle as `start`.
- `busy` = (state ≠ IDLE).
- Asynchronous reset, including mid-copy:
  - State goes to IDLE immediately.
  - All outputs go to 0, including `mem_addr` and `mem_wdata`.
  - Internal registers go to 0.
  - Words already written stay written; no rollback.

## Timing
- `start` is sampled at edge 0. RD_SRC occupies cycle 1.
- A full word takes 3 cycles. A partial final word takes 4.
- `done` is asserted in cycle 1+3·len for full copies, and 2+3·len when the final word is partial. With len=0, `done` is in cycle 1.
- `stall` is high from the `start` cycle through the last WR cycle, and low in the DONE cycle.
- All outputs are decoded from registered state and pointers. The only combinational input path is `start` to `stall`.

## Configuration
- `MEMCPY_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in RD_SRC, LAT_SRC or LAT_DST goes to DONE next cycle with no write.
  - `abort`=1 in WR completes that write, then goes to DONE.
  - `abort` in IDLE or DONE is ignored.
- `MEMCPY_ABORT_EN` undefined: no `abort` port, and every copy runs to completion.

## Test plan
- **Single full word.** len=1, funct3=7, mem[0x100]=0xDEADBEEF, dst=0x200 → one write of mem[0x200]=0xDEADBEEF in cycle 3, `done` in cycle 4, `stall` high in cycles 0–3.
- **Two words, partial final.** len=2, funct3=3, src words 0x11111111 and 0xAAAABBBB, dst words 0x0 and 0x12345678 → dst becomes 0x11111111 and 0x1234BBBB, `done` in cycle 8.
- **Nibble merge.** len=1, funct3=0, src=0xABCDEF9A, dst=0x12345678 → dst=0x1234567A, with a dst read issued in LAT_SRC.
- **Zero length.** len=0 → `done` in cycle 1; `mem_re` and `mem_we` never asserted.
- **Start while busy, then reset.** `start` re-pulsed mid-copy → ignored, pointers unchanged. `rst_n` low during WR → `mem_we`, `stall`, `busy` and `done` go to 0 before the next edge.
- **Abort** (macro defined). Abort in LAT_SRC of word 2 of len=4 → only word 1 written, `done` next cycle. Abort in WR → that word written, then `done`.
